// File: rtl/tty_tx_iot.sv
// Teleprinter/punch device 04: decodes IOT 604x/6035, serialises AC characters onto tx,
// and keeps the printer flag, skip and interrupt-request lines for the CPU side.
module tty_tx_iot #(
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned STOP_BITS  = 1,
    parameter logic [4:0]  F3         = 5'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic [0:11] instruction,
    input  logic [0:11] ac,
    output logic        tx,
    output logic        tskip,
    output logic        int_req,
    output logic        tx_busy
);

    localparam int unsigned DIV      = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned STOP_LEN = STOP_BITS * DIV;
    localparam int unsigned CW       = $clog2(STOP_LEN);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_M1 = CW'(STOP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    tx_state_t     fsm_q, fsm_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;
    logic          flag_q, flag_d;
    logic          int_en_q, int_en_d;
    logic          int_req_q, int_req_d;

    logic          iot_strobe;
    logic          kie;
    logic          load;
    logic          frame_done;
    logic [2:0]    op;
    logic [7:0]    ac_char;
    logic          unused_ac;

    assign unused_ac = ^ac[0:3];

    always_comb begin
        iot_strobe  = (state == F3) && (instruction[0:8] == 9'o604);
        kie         = (state == F3) && (instruction == 12'o6035);
        op          = instruction[9:11];
        ac_char     = ac[4:11];
        load        = iot_strobe && ((op == 3'd4) || (op == 3'd6));
        frame_done  = 1'b0;

        fsm_d       = fsm_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;

        case (fsm_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    fsm_d  = S_START;
                    sh_d   = ac_char;
                    baud_d = '0;
                    tx_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_q == DIV_M1) begin
                    fsm_d  = S_DATA;
                    baud_d = '0;
                    bit_d  = '0;
                    tx_d   = sh_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == DIV_M1) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        fsm_d = S_STOP;
                        bit_d = '0;
                        tx_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == STOP_M1) begin
                    frame_done = 1'b1;
                    baud_d     = '0;
                    // A load landing on the completion edge is treated as a load into an idle shifter.
                    if (hold_full_q) begin
                        fsm_d       = S_START;
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
                    end else if (load) begin
                        fsm_d = S_START;
                        sh_d  = ac_char;
                        tx_d  = 1'b0;
                    end else begin
                        fsm_d = S_IDLE;
                        tx_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        if (load && (fsm_q != S_IDLE) && !(frame_done && !hold_full_q)) begin
            hold_d      = ac_char;
            hold_full_d = 1'b1;
        end

        flag_d = flag_q;
        if (frame_done) begin
            flag_d = 1'b1;
        end
        if (iot_strobe && (op == 3'd0)) begin
            flag_d = 1'b1;
        end
        // IOT clear beats a coincident frame completion.
        if (iot_strobe && ((op == 3'd2) || (op == 3'd6))) begin
            flag_d = 1'b0;
        end

        int_en_d  = kie ? ac[11] : int_en_q;
        int_req_d = flag_q & int_en_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            flag_q      <= 1'b0;
            int_en_q    <= 1'b1;
            int_req_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            flag_q      <= flag_d;
            int_en_q    <= int_en_d;
            int_req_q   <= int_req_d;
        end
    end

    assign tx      = tx_q;
    assign int_req = int_req_q;
    assign tx_busy = (fsm_q != S_IDLE) || hold_full_q;
    assign tskip   = ((instruction == 12'o6041) || (instruction == 12'o6045)) && flag_q;

endmodule

// File: tb/tb_tty_tx_iot.sv
// Bench for tty_tx_iot: directed IOT sequences, with a UART-style monitor that
// decodes every frame on tx and checks it against a queue of expected characters.
module tb_tty_tx_iot;

    localparam logic [4:0]  F3         = 5'd3;
    localparam logic [11:0] IDLE_INSTR = 12'o6041;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic [0:11] ac;
    logic        tx, tskip, int_req, tx_busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    logic [7:0] sb[$];

    tty_tx_iot #(
        .CLOCK_FREQ(16),
        .BAUD_RATE (1),
        .STOP_BITS (1),
        .F3        (F3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .instruction(instruction),
        .ac         (ac),
        .tx         (tx),
        .tskip      (tskip),
        .int_req    (int_req),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drives one IOT for one clock; e is the cycle index of the edge that samples it.
    task automatic iot(input logic [11:0] instr, input logic [11:0] acv,
                       output logic sk, output int e);
        @(posedge clk); #1;
        state = F3; instruction = instr; ac = acv;
        #3 sk = tskip;
        @(posedge clk); #1;
        e = cyc;
        state = 5'd0; instruction = IDLE_INSTR; ac = '0;
    endtask

    // Stop at the negedge following edge number t.
    task automatic at_sample(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    // Frame monitor: first low sample is the first start-bit clock; sample mid-bit after that.
    initial begin : monitor
        logic [7:0] got;
        logic       start_bit, stop_bit, abort;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                abort = 1'b0;
                got = '0; start_bit = 1'b1; stop_bit = 1'b0;
                for (int k = 1; k <= 152; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k == 8) start_bit = tx;
                    else if (k >= 24 && k <= 136 && ((k - 24) % 16) == 0) got = {tx, got[7:1]};
                    else if (k == 152) stop_bit = tx;
                end
                if (!abort) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fails++;
                        $display("FAIL unexpected_frame: got %0h expected none", got);
                    end else begin
                        n_checks--;
                        exp = sb.pop_front();
                        check("frame_data", {4'h0, got}, {4'h0, exp});
                    end
                    check("frame_start_bit", {11'h0, start_bit}, 12'h0);
                    check("frame_stop_bit", {11'h0, stop_bit}, 12'h1);
                end
            end
        end
    end

    initial begin : stim
        logic sk;
        logic busy_ok;
        int   e0, e1, e2, ea, eb, ec;

        reset = 1'b1; state = 5'd0; instruction = IDLE_INSTR; ac = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        at_sample(cyc);
        check("reset_tx", {11'h0, tx}, 12'h1);
        check("reset_flag", {11'h0, tskip}, 12'h0);
        check("reset_int_req", {11'h0, int_req}, 12'h0);
        check("reset_busy", {11'h0, tx_busy}, 12'h0);

        // TLS 0101: frame timing and flag/int_req latency
        iot(12'o6046, 12'o0101, sk, e0); sb.push_back(8'h41);
        at_sample(e0);
        check("t1_start_low", {11'h0, tx}, 12'h0);
        check("t1_busy", {11'h0, tx_busy}, 12'h1);
        at_sample(e0 + 15);  check("t1_start_last", {11'h0, tx}, 12'h0);
        at_sample(e0 + 16);  check("t1_bit0", {11'h0, tx}, 12'h1);
        at_sample(e0 + 32);  check("t1_bit1", {11'h0, tx}, 12'h0);
        at_sample(e0 + 159); check("t1_flag_early", {11'h0, tskip}, 12'h0);
        at_sample(e0 + 160);
        check("t1_flag_set", {11'h0, tskip}, 12'h1);
        check("t1_int_req_lag", {11'h0, int_req}, 12'h0);
        check("t1_busy_done", {11'h0, tx_busy}, 12'h0);
        at_sample(e0 + 161); check("t1_int_req", {11'h0, int_req}, 12'h1);

        // TSF / TSK / TCF and an undefined 604x code
        iot(12'o6046, 12'o0125, sk, e0); sb.push_back(8'h55);
        at_sample(e0 + 40);
        iot(12'o6041, 12'o0000, sk, e1); check("t2_tsf_busy", {11'h0, sk}, 12'h0);
        at_sample(e0 + 165);
        iot(12'o6041, 12'o0000, sk, e1); check("t2_tsf_done", {11'h0, sk}, 12'h1);
        iot(12'o6045, 12'o0000, sk, e1); check("t2_tsk_done", {11'h0, sk}, 12'h1);
        iot(12'o6042, 12'o0000, sk, e1);
        iot(12'o6041, 12'o0000, sk, e1); check("t2_tsf_after_tcf", {11'h0, sk}, 12'h0);
        iot(12'o6047, 12'o0377, sk, e1);
        at_sample(e1 + 2);
        check("t2_other_busy", {11'h0, tx_busy}, 12'h0);
        check("t2_other_flag", {11'h0, tskip}, 12'h0);

        // KIE off then on
        iot(12'o6035, 12'o0000, sk, e1);
        iot(12'o6046, 12'o0001, sk, e0); sb.push_back(8'h01);
        at_sample(e0 + 162);
        check("t3_flag", {11'h0, tskip}, 12'h1);
        check("t3_int_req_off", {11'h0, int_req}, 12'h0);
        iot(12'o6035, 12'o0001, sk, e1);
        at_sample(e1 + 1); check("t3_int_req_on", {11'h0, int_req}, 12'h1);
        iot(12'o6042, 12'o0000, sk, e2);
        at_sample(e2 + 1); check("t3_int_req_cleared", {11'h0, int_req}, 12'h0);

        // Three TPCs in one frame: middle one is overwritten in holding
        iot(12'o6044, 12'o0101, sk, e0);
        iot(12'o6044, 12'o0102, sk, ea);
        iot(12'o6044, 12'o0103, sk, eb);
        sb.push_back(8'h41); sb.push_back(8'h43);
        busy_ok = 1'b1;
        for (int k = eb; k <= e0 + 199; k++) begin
            at_sample(k);
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            if (k == e0 + 159) check("t4_flag_early1", {11'h0, tskip}, 12'h0);
            if (k == e0 + 160) check("t4_flag_set1", {11'h0, tskip}, 12'h1);
        end
        iot(12'o6042, 12'o0000, sk, ec);
        for (int k = ec; k <= e0 + 319; k++) begin
            at_sample(k);
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
        end
        check("t4_busy_throughout", {11'h0, busy_ok}, 12'h1);
        check("t4_flag_early2", {11'h0, tskip}, 12'h0);
        at_sample(e0 + 320);
        check("t4_flag_set2", {11'h0, tskip}, 12'h1);
        check("t4_busy_done", {11'h0, tx_busy}, 12'h0);

        // TLS on the stop-bit end edge: clear wins, new character still sent
        iot(12'o6046, 12'o0125, sk, e0); sb.push_back(8'h55);
        at_sample(e0 + 158);
        iot(12'o6046, 12'o0074, sk, e1); sb.push_back(8'h3C);
        at_sample(e0 + 160);
        check("t5_flag_cleared", {11'h0, tskip}, 12'h0);
        check("t5_new_start", {11'h0, tx}, 12'h0);
        check("t5_busy", {11'h0, tx_busy}, 12'h1);
        at_sample(e0 + 319); check("t5_flag_early", {11'h0, tskip}, 12'h0);
        at_sample(e0 + 320); check("t5_flag_set", {11'h0, tskip}, 12'h1);

        // Reset in the middle of data bit 3
        iot(12'o6035, 12'o0000, sk, e1);
        iot(12'o6044, 12'o0125, sk, e0);
        at_sample(e0 + 70);
        reset = 1'b1;
        at_sample(e0 + 71);
        check("t6_tx", {11'h0, tx}, 12'h1);
        check("t6_flag", {11'h0, tskip}, 12'h0);
        check("t6_busy", {11'h0, tx_busy}, 12'h0);
        check("t6_int_req", {11'h0, int_req}, 12'h0);
        reset = 1'b0;
        iot(12'o6040, 12'o0000, sk, e1);
        at_sample(e1 + 1);
        check("t6_int_en_restored", {11'h0, int_req}, 12'h1);
        iot(12'o6046, 12'o0252, sk, e2); sb.push_back(8'hAA);
        at_sample(e2 + 159); check("t6_flag_early", {11'h0, tskip}, 12'h0);
        at_sample(e2 + 160); check("t6_flag_set", {11'h0, tskip}, 12'h1);
        at_sample(e2 + 170);
        check("all_frames_seen", 12'(sb.size()), 12'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
